// File: rtl/cu_command_arbiter.sv
// Round-robin arbiter sharing the CU command buffer among NUM_REQUESTERS engines, with per-requester outstanding tracking.
// Optional credit gating is compiled in with `define CU_CMD_ARB_CREDIT_EN.
package cu_cmd_arb_pkg;
  typedef struct packed {
    logic       empty;
    logic       alfull;
    logic       full;
  } BufferStatus;

  typedef struct packed {
    logic        valid;
    logic [63:0] address;
    logic [7:0]  size;
    logic [3:0]  tag;
  } CommandBufferLine;

  typedef struct packed {
    logic [7:0] cu_id;
    logic [3:0] tag;
  } ResponseCmd;

  typedef struct packed {
    logic       valid;
    ResponseCmd cmd;
  } ResponseBufferLine;
endpackage

module cu_command_arbiter
  import cu_cmd_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS  = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      enabled_in,
  input  BufferStatus               command_buffer_status,
  input  ResponseBufferLine         response_in,
  input  CommandBufferLine          request_in [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] request_ready_out,
  output CommandBufferLine          command_out,
  output logic [NUM_REQUESTERS-1:0] grant_out,
  output logic [NUM_REQUESTERS-1:0] outstanding_zero_out,
  output logic                      arb_error_out
);
  localparam int IDX = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  CommandBufferLine                         slot [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0]                slot_valid;
  logic [NUM_REQUESTERS-1:0]                elig, gnt_now, accept, rsp_hit, underflow;
  logic [NUM_REQUESTERS-1:0][CNT_BITS-1:0]  out_cnt, cnt_nxt;
  logic [IDX-1:0]                           last_gnt, winner, cand;
  logic                                     any_gnt;

  logic unused_ok;
  assign unused_ok = ^{command_buffer_status.empty, command_buffer_status.full, response_in.cmd.tag};

  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_req
    assign rsp_hit[i] = response_in.valid && (32'(response_in.cmd.cu_id) == i);
`ifdef CU_CMD_ARB_CREDIT_EN
    assign elig[i] = slot_valid[i] & enabled_in & ~command_buffer_status.alfull &
                     (out_cnt[i] < CNT_BITS'(MAX_OUTSTANDING));
`else
    assign elig[i] = slot_valid[i] & enabled_in & ~command_buffer_status.alfull;
`endif
    assign request_ready_out[i] = enabled_in & (~slot_valid[i] | gnt_now[i]);
    assign accept[i]            = request_in[i].valid & request_ready_out[i];
    // a grant and a response in the same cycle cancel out, so only the lone response can underflow
    assign underflow[i] = rsp_hit[i] & ~gnt_now[i] & (out_cnt[i] == '0);
    assign cnt_nxt[i] =
      (gnt_now[i] & ~rsp_hit[i] & ~(&out_cnt[i])) ? out_cnt[i] + CNT_BITS'(1) :
      (rsp_hit[i] & ~gnt_now[i] & (|out_cnt[i]))  ? out_cnt[i] - CNT_BITS'(1) :
                                                     out_cnt[i];
  end

  // search begins one past the last winner and wraps, so the last winner has lowest priority
  always_comb begin
    any_gnt = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = IDX'((int'(last_gnt) + k) % NUM_REQUESTERS);
      if (!any_gnt && elig[cand]) begin
        any_gnt = 1'b1;
        winner  = cand;
      end
    end
    gnt_now = any_gnt ? (NUM_REQUESTERS'(1) << winner) : '0;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      slot_valid           <= '0;
      last_gnt             <= '0;
      out_cnt              <= '0;
      outstanding_zero_out <= '1;
      command_out          <= '0;
      grant_out            <= '0;
      arb_error_out        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        if (accept[i])       slot_valid[i] <= 1'b1;
        else if (gnt_now[i]) slot_valid[i] <= 1'b0;
        outstanding_zero_out[i] <= (cnt_nxt[i] == '0);
      end
      out_cnt   <= cnt_nxt;
      grant_out <= gnt_now;
      if (any_gnt) begin
        command_out       <= slot[winner];
        command_out.valid <= 1'b1;
        last_gnt          <= winner;
      end else begin
        command_out <= '0;
      end
      if (|underflow) arb_error_out <= 1'b1;
    end
  end

  // slot payload is qualified by slot_valid, so it needs no reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQUESTERS; i++)
      if (accept[i]) slot[i] <= request_in[i];
  end
endmodule

// File: tb/tb_cu_command_arbiter.sv
// Bench for cu_command_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_cu_command_arbiter;
  import cu_cmd_arb_pkg::*;

  localparam int N = 4;
`ifdef CU_CMD_ARB_CREDIT_EN
  localparam int MAXO   = 2;
  localparam bit CREDIT = 1'b1;
`else
  localparam int MAXO   = 8;
  localparam bit CREDIT = 1'b0;
`endif
  localparam int CB   = $clog2(MAXO + 1);
  localparam int CMAX = (1 << CB) - 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              rst, en;
  BufferStatus       st;
  ResponseBufferLine rsp;
  CommandBufferLine  req [N];
  logic [N-1:0]      request_ready_out, grant_out, outstanding_zero_out;
  CommandBufferLine  command_out;
  logic              arb_error_out;

  cu_command_arbiter #(.NUM_REQUESTERS(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .rst(rst), .enabled_in(en), .command_buffer_status(st),
    .response_in(rsp), .request_in(req), .request_ready_out(request_ready_out),
    .command_out(command_out), .grant_out(grant_out),
    .outstanding_zero_out(outstanding_zero_out), .arb_error_out(arb_error_out));

  int n_chk = 0, n_fail = 0;

  // reference model: pending commands per requester as queues, counts as plain ints
  CommandBufferLine mq [N][$];
  int               mlast;
  int               mcnt [N];
  bit               merr;
  CommandBufferLine exp_cmd;
  logic [N-1:0]     exp_gnt, exp_zero, exp_rdy, obs_rdy;
  logic             exp_err;

  task automatic tick();
    int w;
    bit g, r;
    @(negedge clock);
    obs_rdy = request_ready_out;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int idx = (mlast + k) % N;
      if (w < 0 && mq[idx].size() > 0 && en && !st.alfull && (!CREDIT || mcnt[idx] < MAXO)) w = idx;
    end
    for (int i = 0; i < N; i++) exp_rdy[i] = en && (mq[i].size() == 0 || w == i);
    if (rst) begin
      for (int i = 0; i < N; i++) begin mq[i].delete(); mcnt[i] = 0; end
      mlast = 0; merr = 0; exp_cmd = '0; exp_gnt = '0;
    end else begin
      exp_cmd = '0; exp_gnt = '0;
      if (w >= 0) begin
        exp_cmd = mq[w].pop_front(); exp_cmd.valid = 1'b1; exp_gnt[w] = 1'b1; mlast = w;
      end
      for (int i = 0; i < N; i++) if (req[i].valid && exp_rdy[i]) mq[i].push_back(req[i]);
      for (int i = 0; i < N; i++) begin
        g = (w == i);
        r = rsp.valid && (int'(rsp.cmd.cu_id) == i);
        if (g && !r && mcnt[i] < CMAX) mcnt[i]++;
        else if (r && !g) begin
          if (mcnt[i] == 0) merr = 1; else mcnt[i]--;
        end
      end
    end
    for (int i = 0; i < N; i++) exp_zero[i] = (mcnt[i] == 0);
    exp_err = merr;
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; st = '0; rsp = '0;
    for (int i = 0; i < N; i++) req[i] = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_chk++; if (command_out !== '0) begin n_fail++; $display("FAIL reset_cmd: got %h want 0", command_out); end
    n_chk++; if (grant_out !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", grant_out); end
    n_chk++; if (outstanding_zero_out !== 4'b1111) begin n_fail++; $display("FAIL reset_zero: got %b want 1111", outstanding_zero_out); end
    n_chk++; if (arb_error_out !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", arb_error_out); end
    n_chk++; if (request_ready_out !== 4'b1111) begin n_fail++; $display("FAIL reset_rdy: got %b want 1111", request_ready_out); end
  endtask

  task automatic test_single();
    logic [63:0] addrs [3];
    logic        ev;
    addrs[0] = 64'h1000; addrs[1] = 64'h1080; addrs[2] = 64'h1100;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      req[0].valid = (j < 3); req[0].address = addrs[j % 3]; req[0].tag = 4'(j);
      tick();
      ev = (j >= 1 && j <= 3);
      n_chk++;
      if (command_out.valid !== ev || (ev && (command_out.address !== addrs[(j + 2) % 3] || grant_out !== 4'b0001))) begin
        n_fail++; $display("FAIL single_cyc%0d: got v=%b a=%h g=%b want v=%b a=%h g=0001", j, command_out.valid, command_out.address, grant_out, ev, addrs[(j + 2) % 3]);
      end
      n_chk++;
      if ({obs_rdy, command_out, grant_out, outstanding_zero_out, arb_error_out} !== {exp_rdy, exp_cmd, exp_gnt, exp_zero, exp_err}) begin
        n_fail++; $display("FAIL single_model: got rdy=%h cmd=%h gnt=%h z=%h err=%b want rdy=%h cmd=%h gnt=%h z=%h err=%b", obs_rdy, command_out, grant_out, outstanding_zero_out, arb_error_out, exp_rdy, exp_cmd, exp_gnt, exp_zero, exp_err);
      end
    end
    n_chk++; if (dut.out_cnt[0] !== 4'd3) begin n_fail++; $display("FAIL single_cnt: got %0d want 3", dut.out_cnt[0]); end
    n_chk++; if (outstanding_zero_out !== 4'b1110) begin n_fail++; $display("FAIL single_zero: got %b want 1110", outstanding_zero_out); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int j = 0; j < 13; j++) begin
      for (int i = 0; i < N; i++) begin
        req[i].valid = 1'b1; req[i].address = {32'(i), 32'(j)};
      end
      tick();
      n_chk++;
      if (j >= 1 && grant_out !== 4'(1 << (j % 4))) begin
        n_fail++; $display("FAIL fair_order_cyc%0d: got %b want %b", j, grant_out, 4'(1 << (j % 4)));
      end
      n_chk++;
      if ({obs_rdy, command_out, grant_out, outstanding_zero_out, arb_error_out} !== {exp_rdy, exp_cmd, exp_gnt, exp_zero, exp_err}) begin
        n_fail++; $display("FAIL fair_model: got rdy=%h cmd=%h gnt=%h z=%h err=%b want rdy=%h cmd=%h gnt=%h z=%h err=%b", obs_rdy, command_out, grant_out, outstanding_zero_out, arb_error_out, exp_rdy, exp_cmd, exp_gnt, exp_zero, exp_err);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int j = 0; j < 17; j++) begin
      for (int i = 0; i < N; i++) begin
        req[i].valid = 1'b1; req[i].address = {32'(i + 16), 32'(j)};
      end
      st.alfull = (j >= 4 && j < 9);
      tick();
      if (j >= 4 && j < 9) begin
        n_chk++;
        if (command_out.valid !== 1'b0 || obs_rdy !== 4'b0000) begin
          n_fail++; $display("FAIL bp_stall_cyc%0d: got v=%b rdy=%b want v=0 rdy=0000", j, command_out.valid, obs_rdy);
        end
      end
      n_chk++;
      if ({obs_rdy, command_out, grant_out, outstanding_zero_out, arb_error_out} !== {exp_rdy, exp_cmd, exp_gnt, exp_zero, exp_err}) begin
        n_fail++; $display("FAIL bp_model: got rdy=%h cmd=%h gnt=%h z=%h err=%b want rdy=%h cmd=%h gnt=%h z=%h err=%b", obs_rdy, command_out, grant_out, outstanding_zero_out, arb_error_out, exp_rdy, exp_cmd, exp_gnt, exp_zero, exp_err);
      end
    end
  endtask

  task automatic test_counters();
    do_reset();
    req[1].valid = 1'b1; req[1].address = 64'hA0; tick();
    req[1].address = 64'hA1; tick();
    req[1].valid = 1'b0; rsp.valid = 1'b1; rsp.cmd.cu_id = 8'd1; tick();
    n_chk++; if (dut.out_cnt[1] !== 4'd1 || command_out.address !== 64'hA1) begin n_fail++; $display("FAIL cnt_simul: got cnt=%0d a=%h want cnt=1 a=a1", dut.out_cnt[1], command_out.address); end
    rsp.cmd.cu_id = 8'd9; tick();
    n_chk++; if (arb_error_out !== 1'b0) begin n_fail++; $display("FAIL cnt_oor_ignored: got err=%b want 0", arb_error_out); end
    rsp.cmd.cu_id = 8'd3; tick();
    n_chk++; if (arb_error_out !== 1'b1 || outstanding_zero_out[3] !== 1'b1) begin n_fail++; $display("FAIL cnt_underflow: got err=%b z3=%b want 1 1", arb_error_out, outstanding_zero_out[3]); end
    rsp.cmd.cu_id = 8'd1; tick();
    rsp = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_chk++;
      if ({obs_rdy, command_out, grant_out, outstanding_zero_out, arb_error_out} !== {exp_rdy, exp_cmd, exp_gnt, exp_zero, exp_err} || arb_error_out !== 1'b1) begin
        n_fail++; $display("FAIL cnt_sticky: got z=%h err=%b want z=%h err=1", outstanding_zero_out, arb_error_out, exp_zero);
      end
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if (arb_error_out !== 1'b0) begin n_fail++; $display("FAIL cnt_err_clear: got %b want 0", arb_error_out); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 3; i++) begin
        req[i].valid = 1'b1; req[i].address = {32'(i + 32), 32'(j)};
      end
      st.alfull = (j >= 4);
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    idle_inputs();
    n_chk++;
    if (command_out !== '0 || grant_out !== 4'b0000 || outstanding_zero_out !== 4'b1111 || arb_error_out !== 1'b0 || request_ready_out !== 4'b1111) begin
      n_fail++; $display("FAIL rstmid_outputs: got cmd=%h g=%b z=%b err=%b rdy=%b want 0 0000 1111 0 1111", command_out, grant_out, outstanding_zero_out, arb_error_out, request_ready_out);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      n_chk++;
      if (command_out.valid !== 1'b0 || grant_out !== 4'b0000) begin
        n_fail++; $display("FAIL rstmid_stale_cyc%0d: got v=%b g=%b want 0 0000", j, command_out.valid, grant_out);
      end
    end
  endtask

  task automatic test_credit();
    int ng;
    do_reset();
    req[2].valid = 1'b1;
    ng = 0;
    for (int j = 0; j < 8; j++) begin
      req[2].address = 64'(j); tick();
      if (grant_out[2]) ng++;
    end
    n_chk++; if (ng !== 2) begin n_fail++; $display("FAIL credit_limit: got %0d grants want 2", ng); end
    ng = 0;
    rsp.valid = 1'b1; rsp.cmd.cu_id = 8'd2;
    for (int j = 0; j < 6; j++) begin
      tick(); rsp = '0;
      if (grant_out[2]) ng++;
    end
    n_chk++; if (ng !== 1) begin n_fail++; $display("FAIL credit_release: got %0d grants want 1", ng); end
  endtask

  task automatic test_random();
    int ri;
    do_reset();
    for (int j = 0; j < 400; j++) begin
      en = ($urandom_range(0, 9) != 0);
      st.alfull = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        req[i].valid = $urandom_range(0, 1);
        req[i].address = {$urandom, $urandom};
        req[i].size = 8'($urandom);
        req[i].tag = 4'($urandom);
      end
      rsp = '0;
      ri = $urandom_range(0, N - 1);
      if (mcnt[ri] > 0 && $urandom_range(0, 2) != 0) begin rsp.valid = 1'b1; rsp.cmd.cu_id = 8'(ri); end
      else if ($urandom_range(0, 19) == 0) begin rsp.valid = 1'b1; rsp.cmd.cu_id = 8'($urandom_range(N, 255)); end
      rsp.cmd.tag = 4'($urandom);
      tick();
      n_chk++;
      if ({obs_rdy, command_out, grant_out, outstanding_zero_out, arb_error_out} !== {exp_rdy, exp_cmd, exp_gnt, exp_zero, exp_err}) begin
        n_fail++; $display("FAIL rand_cyc%0d: got rdy=%h cmd=%h gnt=%h z=%h err=%b want rdy=%h cmd=%h gnt=%h z=%h err=%b", j, obs_rdy, command_out, grant_out, outstanding_zero_out, arb_error_out, exp_rdy, exp_cmd, exp_gnt, exp_zero, exp_err);
      end
    end
  endtask

  initial begin
    mlast = 0; merr = 0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    idle_inputs(); rst = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_counters();
    test_rst_mid();
    if (CREDIT) test_credit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
